imem_responder: RTL

- Instruction-memory responder that serves the core's fetch port: receives the fetch address (the PC) and returns the instruction word combinationally in the same cycle.
- Also owns a streaming valid/ready load port that programs the memory, plus a run/halt state machine.
- The core executes only while `cpu_run` is high; during load or fault the core sees `FILL_WORD`.

---
 rtl/imem_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-latency fetch port for the core, a
// valid/ready load port that programs the array, and an IDLE/LOAD/RUN/ERR
// state machine gating core execution.
module imem_responder #(
    parameter int unsigned          REG_WIDTH  = 16,
    parameter int unsigned          DEPTH_LOG2 = 8,
    parameter logic [REG_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_WIDTH-1:0]  memaddr,
    output logic [REG_WIDTH-1:0]  memdata,
    output logic                  addr_fault,
    output logic                  cpu_run,
    input  logic                  ld_start,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_WIDTH-1:0]  ld_data,
    input  logic                  ld_last,
    input  logic                  run_req,
    output logic                  load_done,
    output logic                  ld_err,
    output logic [DEPTH_LOG2:0]   ld_count
);

    localparam int unsigned         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_done;
    logic [REG_WIDTH-1:0]  r_mem [DEPTH];

    logic                  w_beat;
    logic                  w_write;
    logic [DEPTH_LOG2:0]   w_count_inc;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oob;

    // A restart in the same cycle as a beat discards the beat entirely.
    assign w_beat      = (r_state == S_LOAD) && ld_valid && !ld_start;
    assign w_write     = w_beat && rst_n;
    assign w_count_inc = r_count + 1'b1;

    // Next-state selection; ld_start wins over every other request.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ld_start)     w_state_nxt = S_LOAD;
                else if (run_req) w_state_nxt = S_RUN;
            end
            S_LOAD: begin
                if (ld_start) begin
                    w_state_nxt = S_LOAD;
                end else if (w_beat) begin
                    if (ld_last)                       w_state_nxt = S_RUN;
                    else if (w_count_inc == LP_FULL)   w_state_nxt = S_ERR;
                end
            end
            S_RUN, S_ERR: begin
                if (ld_start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, write pointer, beat counter and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_beat && ld_last;
            if (ld_start) begin
                r_wptr  <= ld_addr;
                r_count <= '0;
            end else if (w_beat) begin
                r_wptr  <= r_wptr + 1'b1;
                r_count <= w_count_inc;
            end
        end
    end

    // Memory array has no reset so a mid-load reset keeps written words.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wptr] <= ld_data;
    end

    assign w_idx = memaddr[DEPTH_LOG2-1:0];

    generate
        if (REG_WIDTH > DEPTH_LOG2) begin : g_oob
            assign w_oob = |memaddr[REG_WIDTH-1:DEPTH_LOG2];
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

    assign cpu_run    = (r_state == S_RUN);
    assign ld_ready   = (r_state == S_LOAD);
    assign ld_err     = (r_state == S_ERR);
    assign load_done  = r_done;
    assign ld_count   = r_count;
    assign addr_fault = cpu_run && w_oob;
    assign memdata    = (cpu_run && !w_oob) ? r_mem[w_idx] : FILL_WORD;

endmodule
